// File: rtl/lif_drv_pkg.sv
// Shared definitions for the LIF neuron driver.
//   - command opcodes carried on cmd_op
//   - driver FSM state encoding
//   - FIRST_NONE: "no spike yet" marker; modules slice it to CNT_BITS
package lif_drv_pkg;

  localparam logic [1:0] OP_LOAD_W = 2'd0;
  localparam logic [1:0] OP_LOAD_I = 2'd1;
  localparam logic [1:0] OP_RUN    = 2'd2;
  localparam logic [1:0] OP_NOP    = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_RUN    = 2'd2,
    S_REPORT = 2'd3
  } drv_state_e;

  localparam logic [31:0] FIRST_NONE = '1;

endpackage

// File: rtl/lif_neuron_driver_tally.sv
// Spike tally for one integration run.
//   clk, reset   : clock, async active-high reset
//   clear        : start of a run; zero count/step, first = all-ones
//   sample_en    : an integration step ends on this edge
//   spike        : neuron spike for that step
//   count        : spikes seen so far
//   first        : step index of the first spike, all-ones if none
//   step         : number of steps sampled so far
module lif_spike_tally
  import lif_drv_pkg::*;
#(
  parameter int CNT_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                sample_en,
  input  logic                spike,
  output logic [CNT_BITS-1:0] count,
  output logic [CNT_BITS-1:0] first,
  output logic [CNT_BITS-1:0] step
);

  localparam logic [CNT_BITS-1:0] NONE = FIRST_NONE[CNT_BITS-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      first <= NONE;
      step  <= '0;
    end else if (clear) begin
      count <= '0;
      first <= NONE;
      step  <= '0;
    end else if (sample_en) begin
      if (spike) begin
        count <= count + 1'b1;
        if (first == NONE) first <= step;
      end
      step <= step + 1'b1;
    end
  end

endmodule

// File: rtl/lif_neuron_driver.sv
// Host-side sequencer for the LIF neuron tile pin protocol.
//   clk, reset          : clock, async active-high reset
//   cmd_valid/ready     : command handshake; ready only in IDLE
//   cmd_op, cmd_data    : opcode and load byte / run length
//   nrn_data            : neuron ui_in (registered)
//   nrn_sel_w           : neuron uio_in[0], 1 = weights (registered)
//   nrn_hold            : neuron uio_in[1], 1 = integrate (registered)
//   nrn_spike           : neuron uo_out[0]
//   res_valid/ready     : run-result handshake
//   res_count, res_first: spikes in run, first spike step (all-ones if none)
module lif_neuron_driver
  import lif_drv_pkg::*;
#(
  parameter int N_STAGES = 3,
  parameter int CNT_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [7:0]          cmd_data,
  output logic [7:0]          nrn_data,
  output logic                nrn_sel_w,
  output logic                nrn_hold,
  input  logic                nrn_spike,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [CNT_BITS-1:0] res_count,
  output logic [CNT_BITS-1:0] res_first
);

  // Bits above the neuron's input count are driven low on the bus.
  localparam logic [7:0] LOAD_MASK = 8'((1 << (2 ** N_STAGES)) - 1);

  drv_state_e          state;
  logic [7:0]          in_shadow;
  logic [CNT_BITS-1:0] run_len;
  logic [CNT_BITS-1:0] step;
  logic                accept;
  logic                last_sample;

  assign cmd_ready = (state == S_IDLE);
  assign res_valid = (state == S_REPORT);
  assign accept    = cmd_valid & cmd_ready;
  // The registered hold marks the edges on which a step completes.
  assign last_sample = nrn_hold && (step == run_len - 1'b1);

  lif_spike_tally #(.CNT_BITS(CNT_BITS)) u_tally (
    .clk       (clk),
    .reset     (reset),
    .clear     (accept && (cmd_op == OP_RUN)),
    .sample_en (nrn_hold),
    .spike     (nrn_spike),
    .count     (res_count),
    .first     (res_first),
    .step      (step)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      nrn_hold  <= 1'b0;
      nrn_sel_w <= 1'b0;
      nrn_data  <= '0;
      in_shadow <= '0;
      run_len   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // Keep re-loading the current inputs so the membrane stays frozen.
          nrn_hold  <= 1'b0;
          nrn_sel_w <= 1'b0;
          nrn_data  <= in_shadow & LOAD_MASK;
          if (accept) begin
            case (cmd_op)
              OP_LOAD_W: begin
                state     <= S_LOAD;
                nrn_sel_w <= 1'b1;
                nrn_data  <= cmd_data & LOAD_MASK;
              end
              OP_LOAD_I: begin
                state     <= S_LOAD;
                nrn_data  <= cmd_data & LOAD_MASK;
                in_shadow <= cmd_data;
              end
              OP_RUN: begin
                run_len <= cmd_data[CNT_BITS-1:0];
                if (cmd_data[CNT_BITS-1:0] == '0) begin
                  state <= S_REPORT;
                end else begin
                  state    <= S_RUN;
                  nrn_hold <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
        S_LOAD: begin
          state     <= S_IDLE;
          nrn_sel_w <= 1'b0;
          nrn_data  <= in_shadow & LOAD_MASK;
        end
        S_RUN: begin
          if (last_sample) begin
            nrn_hold <= 1'b0;
            state    <= S_REPORT;
          end
        end
        S_REPORT: begin
          if (res_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lif_neuron_driver.sv
module tb_lif_neuron_driver;
  import lif_drv_pkg::*;

  localparam int THR = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic [7:0] nrn_data;
  logic       nrn_sel_w, nrn_hold, nrn_spike;
  logic       res_valid, res_ready;
  logic [7:0] res_count, res_first;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lif_neuron_driver #(.N_STAGES(3), .CNT_BITS(8)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .nrn_data(nrn_data), .nrn_sel_w(nrn_sel_w), .nrn_hold(nrn_hold), .nrn_spike(nrn_spike),
    .res_valid(res_valid), .res_ready(res_ready), .res_count(res_count), .res_first(res_first)
  );

  // Toy neuron on the pins: all weights are +1 per set bit, integrate adds
  // popcount(w & in), spike and reset when the membrane reaches THR.
  logic [7:0] nw, ni;
  int nm, npc;
  assign npc = $countones(nw & ni);
  assign nrn_spike = nrn_hold && (nm + npc >= THR);
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      nw <= '0; ni <= '0; nm <= 0;
    end else if (!nrn_hold) begin
      if (nrn_sel_w) nw <= nrn_data;
      else           ni <= nrn_data;
    end else begin
      nm <= (nm + npc >= THR) ? 0 : nm + npc;
    end
  end

  // Total integrate cycles seen on the bus.
  int hold_total = 0;
  always @(negedge clk) if (nrn_hold === 1'b1) hold_total <= hold_total + 1;

  // Host-side view of what the neuron should hold.
  int rw = 0, ri = 0, rm = 0;

  task automatic ref_run(input int n, output int cnt, output int first);
    int pc;
    pc = $countones(rw & ri);
    cnt = 0; first = 255;
    for (int k = 0; k < n; k++) begin
      rm += pc;
      if (rm >= THR) begin
        if (cnt == 0) first = k;
        cnt++;
        rm = 0;
      end
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] d);
    int t;
    t = 0;
    @(negedge clk);
    cmd_op = op; cmd_data = d; cmd_valid = 1'b1;
    while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
    n_checks++;
    if (!cmd_ready) begin n_fail++; $display("FAIL send_timeout: cmd_ready=%0b expected 1", cmd_ready); end
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = OP_NOP;
  endtask

  task automatic load_w(input int v); send(OP_LOAD_W, 8'(v)); rw = v; endtask
  task automatic load_i(input int v); send(OP_LOAD_I, 8'(v)); ri = v; endtask

  task automatic run_cmd(input int n, output int lat, output int cnt, output int first, output int holds);
    int h0;
    @(negedge clk); h0 = hold_total;
    send(OP_RUN, 8'(n));
    lat = 0;
    do begin @(negedge clk); lat++; end while (!res_valid && lat < 400);
    cnt = res_count; first = res_first; holds = hold_total - h0;
    res_ready = 1'b1; @(posedge clk); #1; res_ready = 1'b0;
  endtask

  task automatic test_reset;
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %0b expected 1", cmd_ready); end
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b expected 0", res_valid); end
    n_checks++; if (res_count !== 8'd0) begin n_fail++; $display("FAIL rst_count: got %0d expected 0", res_count); end
    n_checks++; if (res_first !== 8'hFF) begin n_fail++; $display("FAIL rst_first: got %0d expected 255", res_first); end
    n_checks++; if ({nrn_hold, nrn_sel_w, nrn_data} !== 10'd0) begin n_fail++; $display("FAIL rst_bus: got %h expected 0", {nrn_hold, nrn_sel_w, nrn_data}); end
  endtask

  task automatic test_run_silent;
    int lat, cnt, first, holds, ec, ef;
    load_w(8'hFF); load_i(8'h00);
    run_cmd(10, lat, cnt, first, holds); ref_run(10, ec, ef);
    n_checks++; if (cnt !== ec) begin n_fail++; $display("FAIL silent_count: got %0d expected %0d", cnt, ec); end
    n_checks++; if (first !== ef) begin n_fail++; $display("FAIL silent_first: got %0d expected %0d", first, ef); end
    n_checks++; if (holds !== 10) begin n_fail++; $display("FAIL silent_holds: got %0d expected 10", holds); end
  endtask

  task automatic test_spike_run;
    int lat, cnt, first, holds, ec, ef;
    load_i(8'hFF);
    run_cmd(4, lat, cnt, first, holds); ref_run(4, ec, ef);
    n_checks++; if (first !== 0) begin n_fail++; $display("FAIL spike_first: got %0d expected 0", first); end
    n_checks++; if (cnt !== ec) begin n_fail++; $display("FAIL spike_count: got %0d expected %0d", cnt, ec); end
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL spike_latency: got %0d expected 5", lat); end
  endtask

  task automatic test_load_bus;
    load_w(8'h0F);
    @(negedge clk);
    n_checks++; if ({nrn_hold, nrn_sel_w, nrn_data} !== {2'b01, 8'h0F}) begin n_fail++; $display("FAIL loadw_bus: got %h expected 10f", {nrn_hold, nrn_sel_w, nrn_data}); end
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL loadw_busy: got %0b expected 0", cmd_ready); end
    @(negedge clk);
    n_checks++; if ({nrn_sel_w, nrn_data} !== {1'b0, 8'hFF}) begin n_fail++; $display("FAIL loadw_idle: got %h expected ff", {nrn_sel_w, nrn_data}); end
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL loadw_ready: got %0b expected 1", cmd_ready); end
    load_i(8'hAA);
    @(negedge clk);
    n_checks++; if ({nrn_hold, nrn_sel_w, nrn_data} !== {2'b00, 8'hAA}) begin n_fail++; $display("FAIL loadi_bus: got %h expected 0aa", {nrn_hold, nrn_sel_w, nrn_data}); end
    repeat (3) @(negedge clk);
    n_checks++; if ({nrn_sel_w, nrn_data} !== {1'b0, 8'hAA}) begin n_fail++; $display("FAIL loadi_idle: got %h expected aa", {nrn_sel_w, nrn_data}); end
  endtask

  task automatic test_run_zero;
    int lat, cnt, first, holds;
    run_cmd(0, lat, cnt, first, holds);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL zero_latency: got %0d expected 1", lat); end
    n_checks++; if (cnt !== 0 || first !== 255) begin n_fail++; $display("FAIL zero_result: got %0d/%0d expected 0/255", cnt, first); end
    n_checks++; if (holds !== 0) begin n_fail++; $display("FAIL zero_holds: got %0d expected 0", holds); end
  endtask

  task automatic test_back_to_back;
    int ec, ef, t;
    ref_run(2, ec, ef);
    send(OP_RUN, 8'd2);
    t = 0;
    while (!res_valid && t < 50) begin @(negedge clk); t++; end
    cmd_valid = 1'b1; cmd_op = OP_NOP;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if (cmd_ready !== 1'b0 || res_valid !== 1'b1) begin n_fail++; $display("FAIL bp_stall: got ready=%0b valid=%0b expected 0/1", cmd_ready, res_valid); end
      n_checks++; if (res_count !== 8'(ec) || res_first !== 8'(ef)) begin n_fail++; $display("FAIL bp_stable: got %0d/%0d expected %0d/%0d", res_count, res_first, ec, ef); end
    end
    res_ready = 1'b1; @(posedge clk); #1; res_ready = 1'b0;
    @(negedge clk);
    n_checks++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got ready=%0b valid=%0b expected 1/0", cmd_ready, res_valid); end
    @(posedge clk); #1; cmd_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL bp_nop: got %0b expected 1", cmd_ready); end
  endtask

  task automatic test_reset_mid_run;
    int lat, cnt, first, holds, ec, ef;
    load_w(8'hFF); load_i(8'hFF);
    send(OP_RUN, 8'd20);
    repeat (3) @(negedge clk);
    n_checks++; if (nrn_hold !== 1'b1) begin n_fail++; $display("FAIL mid_hold: got %0b expected 1", nrn_hold); end
    reset = 1'b1; #1;
    n_checks++; if ({nrn_hold, nrn_sel_w, nrn_data} !== 10'd0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_bus: got %h ready=%0b expected 0/1", {nrn_hold, nrn_sel_w, nrn_data}, cmd_ready); end
    n_checks++; if (res_valid !== 1'b0 || res_count !== 8'd0 || res_first !== 8'hFF) begin n_fail++; $display("FAIL mid_rst_res: got %0b/%0d/%0d expected 0/0/255", res_valid, res_count, res_first); end
    @(negedge clk); reset = 1'b0;
    rw = 0; ri = 0; rm = 0;
    load_w(8'hFF); load_i(8'h0F);
    run_cmd(6, lat, cnt, first, holds); ref_run(6, ec, ef);
    n_checks++; if (cnt !== ec || first !== ef) begin n_fail++; $display("FAIL post_rst_run: got %0d/%0d expected %0d/%0d", cnt, first, ec, ef); end
    n_checks++; if (lat !== 7 || holds !== 6) begin n_fail++; $display("FAIL post_rst_timing: got lat=%0d holds=%0d expected 7/6", lat, holds); end
  endtask

  task automatic test_random;
    int lat, cnt, first, holds, ec, ef, n;
    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 2) != 0) load_w(int'($urandom_range(0, 255)));
      load_i(int'($urandom_range(0, 255)));
      n = (it % 5 == 4) ? 0 : int'($urandom_range(1, 30));
      run_cmd(n, lat, cnt, first, holds); ref_run(n, ec, ef);
      n_checks++; if (cnt !== ec || first !== ef) begin n_fail++; $display("FAIL rand_result[%0d]: got %0d/%0d expected %0d/%0d (w=%h i=%h n=%0d)", it, cnt, first, ec, ef, rw, ri, n); end
      n_checks++; if (lat !== n + 1 || holds !== n) begin n_fail++; $display("FAIL rand_timing[%0d]: got lat=%0d holds=%0d expected %0d/%0d", it, lat, holds, n + 1, n); end
    end
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_data = '0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    reset = 1'b0;
    test_run_silent();
    test_spike_run();
    test_load_bus();
    test_run_zero();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lif_neuron_driver.md
# lif_neuron_driver

Host-side sequencer that drives the LIF neuron tile's load/integrate pin protocol and collects its spike output. It accepts byte-wide commands over a valid/ready port and turns them into one of three bus actions: weight loads, input loads, or N-step integration runs. For each run it returns a spike count and the step index of the first spike over a second valid/ready port. It sits between a test/host controller and the neuron's ui_in / uio_in[1:0] / uo_out[0] pins.

## Interface
- N_STAGES, 3: neuron adder-tree depth; INPUTS = 2**N_STAGES; legal values 1..3 only (one byte per load).
- CNT_BITS, 8: width of run length, spike count and first-spike index.

- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  driver can accept a command.
- cmd_op  in  2  0 = LOAD_W, 1 = LOAD_I, 2 = RUN, 3 = NOP.
- cmd_data  in  8  load byte (LOAD_W/LOAD_I) or step count N in bits [CNT_BITS-1:0] (RUN).
- nrn_data  out  8  to neuron ui_in.
- nrn_sel_w  out  1  to neuron uio_in[0]; 1 = weights, 0 = inputs.
- nrn_hold  out  1  to neuron uio_in[1]; 0 = load, 1 = integrate.
- nrn_spike  in  1  from neuron uo_out[0].
- res_valid  out  1  run result available.
- res_ready  in  1  host consumes result.
- res_count  out  CNT_BITS  number of spikes in the run.
- res_first  out  CNT_BITS  0-based step of the first spike; all-ones if no spike.

## Operation
- States: IDLE, LOAD, RUN, REPORT. cmd_ready = (state == IDLE). A command is accepted on a clk edge where cmd_valid & cmd_ready.
- All nrn_* outputs are registered.
- IDLE drives nrn_hold=0, nrn_sel_w=0, nrn_data = in_shadow. The neuron keeps re-loading its current inputs, so the membrane stays frozen.
- in_shadow (8b) holds the last LOAD_I byte. Reset value 0, matching the neuron's reset inputs.
- LOAD_W:
  - Accept → LOAD for exactly one cycle with nrn_hold=0, nrn_sel_w=1, nrn_data=cmd_data → IDLE.
- LOAD_I:
  - Same as LOAD_W with nrn_sel_w=0.
  - in_shadow <= cmd_data on the accept edge.
- NOP: accepted, state stays IDLE, no bus change.
- RUN with N > 0:
  - Accept → RUN. Clear the tally, set step = 0, first = all-ones.
  - nrn_hold=1 for exactly N cycles; nrn_data / nrn_sel_w keep the IDLE values.
  - On every edge where the registered nrn_hold=1, sample nrn_spike:
    - if set: count++;
    - if set and first == all-ones: first <= step;
    - then step++.
  - After the N-th sample → REPORT. nrn_hold returns to 0 the same edge.
- RUN with N = 0:
  - Accept → REPORT directly; count = 0, first = all-ones.
  - No integrate cycle is issued.
- REPORT:
  - res_valid=1, with res_count and res_first stable.
  - On res_valid & res_ready → IDLE and res_valid=0.
  - Commands are not accepted while in REPORT.
- Width: count ≤ N ≤ 2**CNT_BITS-1, so there is no overflow. first is never all-ones on a real spike, because step < N.
- Reset (async, any state including mid-RUN):
  - state=IDLE, cmd_ready=1, nrn_hold=0, nrn_sel_w=0, nrn_data=0, in_shadow=0.
  - res_valid=0, res_count=0, res_first=all-ones.
  - A partial run is discarded.

## Timing
- LOAD: accept edge t → load values on the bus during cycle t+1; neuron captures at edge t+2. cmd_ready returns high in cycle t+2. Throughput: one load per 2 cycles.
- RUN N: nrn_hold=1 during cycles t+1..t+N. res_valid rises in cycle t+N+1. Total latency from accept to result is N+1 cycles.
- nrn_spike is combinational from the neuron's registered state. The sample taken on an edge is the spike of that integration step.

## Structure
- Package lif_drv_pkg holds:
  - op encodings OP_LOAD_W/OP_LOAD_I/OP_RUN/OP_NOP;
  - the state enum;
  - localparam FIRST_NONE = all-ones.
- Sub-module lif_spike_tally holds count, first and step.
  - Controls: clear, sample_en, spike.
  - Used once; the FSM stays in lif_neuron_driver.

## Test plan
- Reset, then RUN N=10 with all weights +1 and LOAD_I 0x00 → res_count=0, res_first=255; nrn_hold high for exactly 10 cycles.
- LOAD_I 0xFF, RUN N=4, threshold 5 with the neuron attached → first spike at step 0, res_count matches the neuron reference model; res_valid asserted in cycle accept+5.
- LOAD_W 0x0F then LOAD_I 0xAA → bus shows sel_w=1/0x0F then sel_w=0/0xAA for one cycle each; IDLE afterwards drives 0xAA.
- RUN N=0 → res_valid the cycle after accept, res_count=0, res_first=255, nrn_hold never high.
- Hold res_ready=0 for 5 cycles with cmd_valid=1 → cmd_ready stays 0 and the result stays stable; res_ready=1 → IDLE and the next command is accepted.
- Assert reset in cycle 3 of RUN N=20 → all outputs at reset values immediately; the next RUN reports only its own spikes.
